// File: rtl/uncache_arbiter_if.sv
// Bundle of the two uncache requester ports and the AXI-bridge uncached channel.
// slave = arbiter side, master = requesters plus bridge.
interface uncache_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]      req_en_i;
    logic [DW/8-1:0] req_wsel0;
    logic [AW-1:0]   req_addr0;
    logic [DW-1:0]   req_wdata0;
    logic [DW/8-1:0] req_wsel1;
    logic [AW-1:0]   req_addr1;
    logic [DW-1:0]   req_wdata1;
    logic [1:0]      req_accept_o;
    logic [1:0]      req_fin_o;
    logic [DW-1:0]   req_rdata_o;
    logic [1:0]      stallreq_o;
    logic            axi_en;
    logic            accept;
    logic [DW/8-1:0] axi_wsel;
    logic [AW-1:0]   axi_addr;
    logic [DW-1:0]   axi_wdata;
    logic [DW-1:0]   axi_rdata;
    logic            fin;
    logic            busy_o;

    modport slave (
        input  req_en_i, req_wsel0, req_addr0, req_wdata0,
        input  req_wsel1, req_addr1, req_wdata1,
        input  accept, axi_rdata, fin,
        output req_accept_o, req_fin_o, req_rdata_o, stallreq_o,
        output axi_en, axi_wsel, axi_addr, axi_wdata, busy_o
    );

    modport master (
        output req_en_i, req_wsel0, req_addr0, req_wdata0,
        output req_wsel1, req_addr1, req_wdata1,
        output accept, axi_rdata, fin,
        input  req_accept_o, req_fin_o, req_rdata_o, stallreq_o,
        input  axi_en, axi_wsel, axi_addr, axi_wdata, busy_o
    );
endinterface

// File: rtl/uncache_arbiter.sv
// Two-port arbiter (I-side = port0, D-side = port1) in front of the AXI bridge
// uncached channel; one single-beat access outstanding at a time.
module uncache_arbiter #(
    parameter bit RR_EN = 1'b1,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic              clk,
    input logic              rst,
    uncache_arbiter_if.slave bus
);
    localparam int SW = DW / 8;

    // Gray-coded so each transition flips a single bit.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b11,
        DONE  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            win;
    logic            axi_en_q, axi_en_d;
    logic [SW-1:0]   wsel_q, wsel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [1:0]      acc_q, acc_d;
    logic [1:0]      fin_q, fin_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    always_comb begin
        case (bus.req_en_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = RR_EN ? ~last_q : 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        axi_en_d = axi_en_q;
        wsel_d   = wsel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        acc_d    = '0;
        fin_d    = '0;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_en_i) begin
                    owner_d  = win;
                    last_d   = win;
                    axi_en_d = 1'b1;
                    wsel_d   = win ? bus.req_wsel1  : bus.req_wsel0;
                    addr_d   = win ? bus.req_addr1  : bus.req_addr0;
                    wdata_d  = win ? bus.req_wdata1 : bus.req_wdata0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.accept) begin
                    axi_en_d       = 1'b0;
                    wsel_d         = '0;
                    addr_d         = '0;
                    wdata_d        = '0;
                    acc_d[owner_q] = 1'b1;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (bus.fin) begin
                    rdata_d        = bus.axi_rdata;
                    fin_d[owner_q] = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            axi_en_q <= 1'b0;
            wsel_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            acc_q    <= '0;
            fin_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            axi_en_q <= axi_en_d;
            wsel_q   <= wsel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            acc_q    <= acc_d;
            fin_q    <= fin_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.axi_en       = axi_en_q;
    assign bus.axi_wsel     = wsel_q;
    assign bus.axi_addr     = addr_q;
    assign bus.axi_wdata    = wdata_q;
    assign bus.req_accept_o = acc_q;
    assign bus.req_fin_o    = fin_q;
    assign bus.req_rdata_o  = rdata_q;
    assign bus.stallreq_o   = bus.req_en_i & ~fin_q;
    assign bus.busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_uncache_arbiter.sv
// Bench for uncache_arbiter: directed cases plus randomized traffic against a
// request-level model (pending mask, last grant, per-port request fields).
module tb_uncache_arbiter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    uncache_arbiter_if #(.AW(32), .DW(32)) u ();
    uncache_arbiter_if #(.AW(32), .DW(32)) f ();

    uncache_arbiter #(.RR_EN(1'b1), .AW(32), .DW(32)) dut_rr (
        .clk(clk), .rst(rst), .bus(u)
    );
    uncache_arbiter #(.RR_EN(1'b0), .AW(32), .DW(32)) dut_fp (
        .clk(clk), .rst(rst), .bus(f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  pend;
    logic        last_g;
    logic [3:0]  ws [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        u.req_en_i   = pend;
        u.req_wsel0  = ws[0];
        u.req_addr0  = ad[0];
        u.req_wdata0 = wd[0];
        u.req_wsel1  = ws[1];
        u.req_addr1  = ad[1];
        u.req_wdata1 = wd[1];
    endtask

    task automatic new_req(input int p);
        ws[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        ad[p] = $urandom;
        wd[p] = $urandom;
        pend[p] = 1'b1;
    endtask

    // One complete access of the RR DUT, entered at a negedge with the
    // DUT idle and pend != 0 already driven.
    task automatic access(input int adly, input int fdly,
                          input logic [31:0] rd);
        int w;
        logic [1:0] oh;
        case (pend)
            2'b01:   w = 0;
            2'b10:   w = 1;
            default: w = last_g ? 0 : 1;
        endcase
        last_g = w[0];
        oh = 2'b01 << w;
        @(negedge clk);
        chk("grant_en", u.axi_en, 1);
        chk("grant_addr", u.axi_addr, ad[w]);
        chk("grant_wsel", u.axi_wsel, ws[w]);
        chk("grant_wdata", u.axi_wdata, wd[w]);
        chk("grant_busy", u.busy_o, 1);
        chk("grant_stall", u.stallreq_o, pend);
        for (int i = 0; i < adly; i++) begin
            u.fin = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            u.accept = 1'b0;
            @(negedge clk);
            chk("issue_en", u.axi_en, 1);
            chk("issue_addr", u.axi_addr, ad[w]);
            chk("issue_wdata", u.axi_wdata, wd[w]);
            chk("issue_nofin", u.req_fin_o, 0);
            chk("issue_noacc", u.req_accept_o, 0);
        end
        u.fin = 1'b0;
        u.accept = 1'b1;
        @(negedge clk);
        u.accept = 1'b0;
        chk("acc_pulse", u.req_accept_o, oh);
        chk("acc_en0", u.axi_en, 0);
        chk("acc_addr0", u.axi_addr, 0);
        chk("acc_wsel0", u.axi_wsel, 0);
        chk("acc_wdata0", u.axi_wdata, 0);
        for (int i = 0; i < fdly; i++) begin
            u.accept = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wait_noacc", u.req_accept_o, 0);
            chk("wait_nofin", u.req_fin_o, 0);
            chk("wait_stall", u.stallreq_o, pend);
        end
        u.accept = 1'b0;
        u.axi_rdata = rd;
        u.fin = 1'b1;
        @(negedge clk);
        u.fin = 1'b0;
        u.axi_rdata = $urandom;
        chk("fin_pulse", u.req_fin_o, oh);
        chk("fin_rdata", u.req_rdata_o, rd);
        chk("fin_stall", u.stallreq_o, pend & ~oh);
        chk("done_busy", u.busy_o, 1);
        pend[w] = 1'b0;
        drive();
        @(negedge clk);
        chk("idle_busy", u.busy_o, 0);
        chk("idle_en", u.axi_en, 0);
        chk("idle_nofin", u.req_fin_o, 0);
        chk("idle_rdata", u.req_rdata_o, rd);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        pend = 2'b00;
        last_g = 1'b1;
        for (int p = 0; p < 2; p++) begin
            ws[p] = '0;
            ad[p] = '0;
            wd[p] = '0;
        end
        drive();
        u.accept = 1'b0;
        u.fin = 1'b0;
        u.axi_rdata = '0;
        f.req_en_i = '0;
        f.req_wsel0 = '0;
        f.req_addr0 = '0;
        f.req_wdata0 = '0;
        f.req_wsel1 = '0;
        f.req_addr1 = '0;
        f.req_wdata1 = '0;
        f.accept = 1'b0;
        f.fin = 1'b0;
        f.axi_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_en", u.axi_en, 0);
        chk("rst_addr", u.axi_addr, 0);
        chk("rst_acc", u.req_accept_o, 0);
        chk("rst_fin", u.req_fin_o, 0);
        chk("rst_rdata", u.req_rdata_o, 0);
        chk("rst_busy", u.busy_o, 0);
        chk("rst_fp_en", f.axi_en, 0);
        rst = 1'b1;

        // Both request from reset: grants 0,1,0.
        new_req(0);
        new_req(1);
        drive();
        access(0, 1, $urandom);
        chk("rr_first", {31'd0, last_g}, 0);
        new_req(0);
        drive();
        access(1, 0, $urandom);
        chk("rr_second", {31'd0, last_g}, 1);
        new_req(1);
        drive();
        access(0, 2, $urandom);
        chk("rr_third", {31'd0, last_g}, 0);
        access(0, 0, $urandom);

        // Port0 read of the boot vector.
        pend = 2'b01;
        ws[0] = 4'h0;
        ad[0] = 32'h1FC0_0000;
        wd[0] = 32'h0;
        drive();
        access(0, 2, 32'h2402_0001);

        // Port1 partial write.
        pend = 2'b10;
        ws[1] = 4'b0011;
        ad[1] = 32'hBFAF_F000;
        wd[1] = 32'h1234_5678;
        drive();
        access(2, 1, $urandom);

        // Accept withheld 10 cycles with stray fin pulses.
        new_req($urandom_range(0, 1));
        drive();
        access(10, 1, $urandom);

        for (int n = 0; n < 40; n++) begin
            int nb;
            nb = $urandom_range(0, 3);
            if (pend == 2'b00 && nb == 0) nb = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++)
                if (nb[p] && !pend[p]) new_req(p);
            drive();
            access($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // Async reset while waiting for fin.
        pend = 2'b00;
        new_req(1);
        drive();
        @(negedge clk);
        u.accept = 1'b1;
        @(negedge clk);
        u.accept = 1'b0;
        chk("r6_acc", u.req_accept_o, 2'b10);
        #2 rst = 1'b0;
        pend = 2'b00;
        drive();
        #1;
        chk("r6_en", u.axi_en, 0);
        chk("r6_acc0", u.req_accept_o, 0);
        chk("r6_rdata", u.req_rdata_o, 0);
        chk("r6_busy", u.busy_o, 0);
        @(negedge clk);
        rst = 1'b1;
        last_g = 1'b1;
        u.fin = 1'b1;
        @(negedge clk);
        u.fin = 1'b0;
        chk("r6_nofin", u.req_fin_o, 0);
        chk("r6_idle", u.busy_o, 0);
        new_req(0);
        new_req(1);
        drive();
        access(1, 1, $urandom);
        chk("r6_first", {31'd0, last_g}, 0);
        access(0, 0, $urandom);

        // Fixed priority: port1 first, then port0.
        f.req_en_i = 2'b11;
        f.req_addr0 = 32'h0000_1000;
        f.req_wdata0 = 32'hA5A5_0000;
        f.req_addr1 = 32'h0000_2000;
        f.req_wdata1 = 32'h5A5A_1111;
        f.req_wsel1 = 4'hF;
        @(negedge clk);
        chk("fp_addr1", f.axi_addr, 32'h0000_2000);
        chk("fp_wsel1", f.axi_wsel, 4'hF);
        f.accept = 1'b1;
        @(negedge clk);
        f.accept = 1'b0;
        chk("fp_acc1", f.req_accept_o, 2'b10);
        f.axi_rdata = 32'hCAFE_0001;
        f.fin = 1'b1;
        @(negedge clk);
        f.fin = 1'b0;
        chk("fp_fin1", f.req_fin_o, 2'b10);
        chk("fp_rd1", f.req_rdata_o, 32'hCAFE_0001);
        f.req_en_i = 2'b01;
        repeat (2) @(negedge clk);
        chk("fp_addr0", f.axi_addr, 32'h0000_1000);
        chk("fp_en0", f.axi_en, 1);
        f.accept = 1'b1;
        @(negedge clk);
        f.accept = 1'b0;
        chk("fp_acc0", f.req_accept_o, 2'b01);
        f.fin = 1'b1;
        @(negedge clk);
        f.fin = 1'b0;
        f.req_en_i = 2'b00;
        chk("fp_fin0", f.req_fin_o, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
